// File: rtl/alu_pkg.sv
// Shared definitions for the ALU family: op encoding, serial FSM states and
// small helpers used by the bit-serial responder.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // SUB and SLT compute a + ~b + 1, so they share the inverted-operand path.
  function automatic logic is_inv(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || is_inv(op);
  endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// One-bit combinational ALU slice: bitwise AND/OR or full-adder sum/carry.
module serial_alu_bit
  import alu_pkg::*;
(
  input  logic       a_bit,
  input  logic       b_bit,
  input  logic       carry_in,
  input  logic [2:0] op,
  output logic       r_bit,
  output logic       carry_out
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    r_bit     = 1'b0;
    carry_out = carry_in;
    if (op == OP_AND) begin
      r_bit = a_bit & b_bit;
    end else if (op == OP_OR) begin
      r_bit = a_bit | b_bit;
    end else if (is_arith(op)) begin
      r_bit     = a_bit ^ b_bit ^ carry_in;
      carry_out = (a_bit & b_bit) | (a_bit & carry_in) | (b_bit & carry_in);
    end
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU behind valid/ready handshakes; one result bit per clock, LSB first.
// Define SERIAL_ALU_OVF_EN to expose a registered signed-overflow output.
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             ex
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [2:0]       op_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             r_bit, carry_out;
  logic             accept, last;
  logic             ovf_w;
  logic [WIDTH-1:0] res_nx, z_fin;

  serial_alu_bit u_bit (
    .a_bit     (a_sr[0]),
    .b_bit     (b_sr[0]),
    .carry_in  (carry),
    .op        (op_r),
    .r_bit     (r_bit),
    .carry_out (carry_out)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (state == BUSY) && (cnt == CW'(WIDTH - 1));

  // Sign/overflow only mean something on the MSB cycle, where they are consumed.
  assign ovf_w  = carry ^ carry_out;
  assign res_nx = {r_bit, res_sr};

  always_comb begin
    z_fin = '0;
    if (op_r == OP_SLT) begin
      z_fin = {{(WIDTH-1){1'b0}}, r_bit ^ ovf_w};
    end else if (op_r == OP_AND || op_r == OP_OR || op_r == OP_ADD || op_r == OP_SUB) begin
      z_fin = res_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      op_r   <= OP_AND;
      carry  <= 1'b0;
      cnt    <= '0;
      z      <= '0;
      ex     <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= is_inv(op) ? ~b : b;
      op_r  <= op;
      carry <= is_inv(op);
      cnt   <= '0;
    end else if (state == BUSY) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nx[WIDTH-1:1];
      carry  <= carry_out;
      cnt    <= cnt + 1'b1;
      if (last) begin
        z  <= z_fin;
        ex <= (z_fin == '0);
`ifdef SERIAL_ALU_OVF_EN
        ovf <= (op_r == OP_ADD || op_r == OP_SUB) ? ovf_w : 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Directed self-checking bench for serial_alu (WIDTH=32), with a small
// reference model for the cross-check loop.
module tb_serial_alu;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       op = 3'b000;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] z;
  logic             ex;
`ifdef SERIAL_ALU_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int failures = 0;

  serial_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .ex        (ex)
`ifdef SERIAL_ALU_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_z(input logic [31:0] ra, input logic [31:0] rb,
                                        input logic [2:0] rop);
    case (rop)
      3'b000:  return ra & rb;
      3'b001:  return ra | rb;
      3'b010:  return ra + rb;
      3'b110:  return ra - rb;
      3'b111:  return {31'd0, $signed(ra) < $signed(rb)};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [31:0] ra, input logic [31:0] rb,
                                   input logic [2:0] rop);
    logic [31:0] s;
    s = ref_z(ra, rb, rop);
    if (rop == 3'b010) return (ra[31] == rb[31]) && (s[31] != ra[31]);
    if (rop == 3'b110) return (ra[31] != rb[31]) && (s[31] != ra[31]);
    return 1'b0;
  endfunction

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic [2:0] top);
    @(negedge clk);
    a = ta;
    b = tb_v;
    op = top;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ov_low"}, out_valid, 1'b0);
    check({tag, "_ir_high"}, in_ready, 1'b1);
  endtask

  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [2:0] top, input logic [31:0] ez, input logic eex,
                       input logic eovf);
    int n;
    send(ta, tb_v, top);
    wait_done(n);
    check({tag, "_lat"}, 64'(n), 64'(WIDTH));
    check({tag, "_z"}, z, ez);
    check({tag, "_ex"}, ex, eex);
`ifdef SERIAL_ALU_OVF_EN
    check({tag, "_ovf"}, ovf, eovf);
`else
    if (eovf === 1'bx) $display("unexpected unknown overflow expectation");
`endif
    take(tag);
  endtask

  initial begin
    int n;
    int extra;
    logic [31:0] zs;
    logic [2:0] ops [5];

    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_z", z, 32'd0);
    check("rst_ex", ex, 1'b0);
    rst_n = 1'b1;

    do_op("and", 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 1'b0, 1'b0);
    do_op("add_wrap", 32'hFFFFFFFF, 32'h1, 3'b010, 32'h0, 1'b1, 1'b0);
    do_op("add_ovf", 32'h7FFFFFFF, 32'h1, 3'b010, 32'h80000000, 1'b0, 1'b1);
    do_op("slt_neg", 32'hFFFFFFFE, 32'h3, 3'b111, 32'h1, 1'b0, 1'b0);
    do_op("slt_ovfc", 32'h80000000, 32'h1, 3'b111, 32'h1, 1'b0, 1'b0);
    do_op("slt_eq", 32'h5, 32'h5, 3'b111, 32'h0, 1'b1, 1'b0);
    do_op("or", 32'h0000_00F0, 32'h0F00_000F, 3'b001, 32'h0F00_00FF, 1'b0, 1'b0);

    // SUB with backpressure held for 5 cycles in DONE.
    send(32'hFFFFFFFE, 32'h3, 3'b110);
    wait_done(n);
    check("sub_lat", 64'(n), 64'(WIDTH));
    check("sub_z", z, 32'hFFFFFFFB);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_z", z, 32'hFFFFFFFB);
      check("bp_ex", ex, 1'b0);
    end
    take("sub_bp");

    // in_valid pulses during BUSY and DONE must be ignored.
    send(32'h12345678, 32'h11111111, 3'b010);
    repeat (5) @(posedge clk);
    @(negedge clk);
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    op = 3'b110;
    in_valid = 1'b1;
    check("busy_in_ready", in_ready, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(n);
    check("ign_lat", 64'(n), 64'(WIDTH - 7));
    check("ign_z", z, 32'h23456789);
    @(negedge clk);
    in_valid = 1'b1;
    check("done_in_ready", in_ready, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("ign_done_z", z, 32'h23456789);
    take("ign");
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) extra++;
    end
    check("no_extra_result", 64'(extra), 64'd0);

    // Reset at counter=10 aborts the operation.
    send(32'hAAAA5555, 32'h1234, 3'b010);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) extra++;
    end
    check("midrst_no_result", 64'(extra), 64'd0);

    do_op("post_rst_add", 32'h3, 32'h4, 3'b010, 32'h7, 1'b0, 1'b0);
    do_op("unsupported", 32'hDEADBEEF, 32'h12345678, 3'b011, 32'h0, 1'b1, 1'b0);
    do_op("unsupported_after_nonzero", 32'h1, 32'h1, 3'b100, 32'h0, 1'b1, 1'b0);

    ops[0] = 3'b000;
    ops[1] = 3'b001;
    ops[2] = 3'b010;
    ops[3] = 3'b110;
    ops[4] = 3'b111;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 10; j++) begin
        logic [31:0] ra, rb;
        ra = $urandom;
        rb = $urandom;
        if (j == 0) rb = ra;
        zs = ref_z(ra, rb, ops[k]);
        do_op($sformatf("rnd_op%0d_%0d", ops[k], j), ra, rb, ops[k], zs, zs == 32'd0,
              ref_ovf(ra, rb, ops[k]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
